cdc_handshake_sync: RTL and testbench

Parametrised clock-domain-crossing block for multi-bit data from domain A (clk_a) to domain B (clk_b) over a four-phase req/ack handshake. Includes a per-domain reset synchroniser so the shared async_rst asserts asynchronously in both domains and deasserts synchronously in each. Replaces direct use of async_rst across domains (lint rule CDC_004) and unsynchronised single-bit data crossings.

---
 rtl/cdc_handshake_sync.sv | 181 ++++++++++++++++++
 tb/tb_cdc_handshake_sync.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_sync.sv
// Four-phase req/ack crossing of a WIDTH-bit word from clk_a to clk_b, with one reset
// synchroniser per domain so async_rst asserts at once and releases cleanly in each.
module cdc_handshake_sync #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_STAGES  = 2
) (
    input  logic             clk_a,
    input  logic             async_rst,
    input  logic             clk_b,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_rst_n_sync,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_rst_n_sync
);

    localparam logic [1:0] SRC_IDLE  = 2'd0;
    localparam logic [1:0] SRC_REQ   = 2'd1;
    localparam logic [1:0] SRC_CLR   = 2'd2;
    localparam logic [1:0] DST_WAIT  = 2'd0;
    localparam logic [1:0] DST_VALID = 2'd1;
    localparam logic [1:0] DST_ACK   = 2'd2;

    logic [RST_STAGES-1:0]  rst_a_q;
    logic [RST_STAGES-1:0]  rst_b_q;

    logic [1:0]             src_state_q, src_state_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;

    logic [1:0]             dst_state_q, dst_state_d;
    logic                   ack_q, ack_d;
    logic                   b_valid_q, b_valid_d;
    logic [WIDTH-1:0]       b_data_q, b_data_d;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_sync;

    // Reset synchronisers: async clear, release after RST_STAGES local edges.
    always_ff @(posedge clk_a or negedge async_rst) begin
        if (!async_rst) begin
            rst_a_q <= '0;
        end else begin
            rst_a_q <= {rst_a_q[RST_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk_b or negedge async_rst) begin
        if (!async_rst) begin
            rst_b_q <= '0;
        end else begin
            rst_b_q <= {rst_b_q[RST_STAGES-2:0], 1'b1};
        end
    end

    assign a_rst_n_sync = rst_a_q[RST_STAGES-1];
    assign b_rst_n_sync = rst_b_q[RST_STAGES-1];

    // Source side (clk_a)
    always_ff @(posedge clk_a or negedge a_rst_n_sync) begin
        if (!a_rst_n_sync) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_q};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];
    assign a_ready  = a_rst_n_sync && (src_state_q == SRC_IDLE);

    always_comb begin
        src_state_d = src_state_q;
        req_d       = req_q;
        hold_d      = hold_q;
        case (src_state_q)
            SRC_IDLE: begin
                if (a_valid && a_ready) begin
                    hold_d      = a_data;
                    req_d       = 1'b1;
                    src_state_d = SRC_REQ;
                end
            end
            SRC_REQ: begin
                if (ack_sync) begin
                    req_d       = 1'b0;
                    src_state_d = SRC_CLR;
                end
            end
            SRC_CLR: begin
                if (!ack_sync) begin
                    src_state_d = SRC_IDLE;
                end
            end
            default: begin
                req_d       = 1'b0;
                src_state_d = SRC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a or negedge a_rst_n_sync) begin
        if (!a_rst_n_sync) begin
            src_state_q <= SRC_IDLE;
            req_q       <= 1'b0;
            hold_q      <= '0;
        end else begin
            src_state_q <= src_state_d;
            req_q       <= req_d;
            hold_q      <= hold_d;
        end
    end

    // Destination side (clk_b). hold_q is quasi-static while req is seen high,
    // so it is sampled directly without per-bit synchronisers.
    always_ff @(posedge clk_b or negedge b_rst_n_sync) begin
        if (!b_rst_n_sync) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
        end
    end

    assign req_sync = req_sync_q[SYNC_STAGES-1];

    always_comb begin
        dst_state_d = dst_state_q;
        ack_d       = ack_q;
        b_valid_d   = b_valid_q;
        b_data_d    = b_data_q;
        case (dst_state_q)
            DST_WAIT: begin
                if (req_sync) begin
                    b_data_d    = hold_q;
                    b_valid_d   = 1'b1;
                    dst_state_d = DST_VALID;
                end
            end
            DST_VALID: begin
                if (b_ready) begin
                    b_valid_d   = 1'b0;
                    ack_d       = 1'b1;
                    dst_state_d = DST_ACK;
                end
            end
            DST_ACK: begin
                if (!req_sync) begin
                    ack_d       = 1'b0;
                    dst_state_d = DST_WAIT;
                end
            end
            default: begin
                ack_d       = 1'b0;
                b_valid_d   = 1'b0;
                dst_state_d = DST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_b or negedge b_rst_n_sync) begin
        if (!b_rst_n_sync) begin
            dst_state_q <= DST_WAIT;
            ack_q       <= 1'b0;
            b_valid_q   <= 1'b0;
            b_data_q    <= '0;
        end else begin
            dst_state_q <= dst_state_d;
            ack_q       <= ack_d;
            b_valid_q   <= b_valid_d;
            b_data_q    <= b_data_d;
        end
    end

    assign b_valid = b_valid_q;
    assign b_data  = b_data_q;

endmodule

// File: tb/tb_cdc_handshake_sync.sv
// Directed bench for cdc_handshake_sync: an 8-bit default instance for latency, stall and
// reset cases, and a 32-bit SYNC_STAGES=3 instance for a clock-ratio sweep with a scoreboard.
`timescale 1ns / 1ps
module tb_cdc_handshake_sync;

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic async_rst = 1'b0;
    real  half_a = 5.0;
    real  half_b = 13.5;
    real  skew_b = 0.0;
    bit   run_b = 1'b1;

    logic        a_valid8 = 1'b0;
    logic        a_ready8;
    logic [7:0]  a_data8 = 8'h00;
    logic        a_rst8;
    logic        b_valid8;
    logic        b_ready8 = 1'b0;
    logic [7:0]  b_data8;
    logic        b_rst8;

    logic        a_valid32 = 1'b0;
    logic        a_ready32;
    logic [31:0] a_data32 = 32'h0;
    logic        a_rst32;
    logic        b_valid32;
    logic        b_ready32 = 1'b0;
    logic [31:0] b_data32;
    logic        b_rst32;

    int n_tests = 0;
    int n_fail = 0;
    int n_acc32 = 0;
    logic [7:0]  rx8[$];
    logic [31:0] rx32[$];
    logic [31:0] exp32[$];

    cdc_handshake_sync u_dut8 (
        .clk_a        (clk_a),
        .async_rst    (async_rst),
        .clk_b        (clk_b),
        .a_valid      (a_valid8),
        .a_ready      (a_ready8),
        .a_data       (a_data8),
        .a_rst_n_sync (a_rst8),
        .b_valid      (b_valid8),
        .b_ready      (b_ready8),
        .b_data       (b_data8),
        .b_rst_n_sync (b_rst8)
    );

    cdc_handshake_sync #(
        .WIDTH       (32),
        .SYNC_STAGES (3),
        .RST_STAGES  (2)
    ) u_dut32 (
        .clk_a        (clk_a),
        .async_rst    (async_rst),
        .clk_b        (clk_b),
        .a_valid      (a_valid32),
        .a_ready      (a_ready32),
        .a_data       (a_data32),
        .a_rst_n_sync (a_rst32),
        .b_valid      (b_valid32),
        .b_ready      (b_ready32),
        .b_data       (b_data32),
        .b_rst_n_sync (b_rst32)
    );

    initial forever #(half_a) clk_a = ~clk_a;

    initial begin
        forever begin
            #(half_b);
            if (skew_b != 0.0) begin
                #(skew_b);
                skew_b = 0.0;
            end
            if (run_b) clk_b = ~clk_b;
        end
    end

    always @(posedge clk_b) begin
        if (b_valid8 && b_ready8) rx8.push_back(b_data8);
        if (b_valid32 && b_ready32) n_acc32 = n_acc32 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send8(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk_a);
        a_valid8 = 1'b1;
        a_data8  = d;
        for (int k = 0; k < 1000; k++) begin
            if (a_ready8) begin
                @(posedge clk_a);
                ok = 1'b1;
                break;
            end
            @(negedge clk_a);
        end
    endtask

    task automatic wait_a_ready8(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_a);
            if (a_ready8) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_b_valid8(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk_b);
            if (b_valid8) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Releases async_rst and checks each domain leaves reset on its 2nd local edge.
    task automatic release_and_check(input string tag);
        @(negedge clk_a);
        async_rst = 1'b1;
        fork
            begin
                @(posedge clk_a);
                #1 check({tag, " a_rst edge1"}, {31'b0, a_rst8}, 32'd0);
                @(posedge clk_a);
                #1 check({tag, " a_rst edge2"}, {31'b0, a_rst8}, 32'd1);
                check({tag, " a_rst32 edge2"}, {31'b0, a_rst32}, 32'd1);
                check({tag, " a_ready idle"}, {31'b0, a_ready8}, 32'd1);
            end
            begin
                @(posedge clk_b);
                #1 check({tag, " b_rst edge1"}, {31'b0, b_rst8}, 32'd0);
                @(posedge clk_b);
                #1 check({tag, " b_rst edge2"}, {31'b0, b_rst8}, 32'd1);
            end
        join
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: time limit reached, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit stable;
        int base;
        int got;

        // Reset state
        #2;
        check("rst a_rst_n_sync", {31'b0, a_rst8}, 32'd0);
        check("rst b_rst_n_sync", {31'b0, b_rst8}, 32'd0);
        check("rst a_ready", {31'b0, a_ready8}, 32'd0);
        check("rst b_valid", {31'b0, b_valid8}, 32'd0);
        check("rst b_data", {24'b0, b_data8}, 32'd0);
        release_and_check("init");

        // Single transfer with latency check
        send8(8'hA5, ok);
        check("single accept", {31'b0, ok}, 32'd1);
        repeat (2) @(posedge clk_b);
        #1 check("single b_valid edge2", {31'b0, b_valid8}, 32'd0);
        @(posedge clk_b);
        #1 check("single b_valid edge3", {31'b0, b_valid8}, 32'd1);
        check("single b_data", {24'b0, b_data8}, 32'h0000_00A5);
        check("single a_ready busy", {31'b0, a_ready8}, 32'd0);
        @(negedge clk_a);
        a_valid8 = 1'b0;
        @(negedge clk_b);
        b_ready8 = 1'b1;
        wait_a_ready8(ok);
        check("single a_ready back", {31'b0, ok}, 32'd1);
        check("single count", rx8.size(), 32'd1);
        check("single data", {24'b0, rx8[0]}, 32'h0000_00A5);

        // Back-to-back, 0x01..0x10
        base = rx8.size();
        got = 0;
        for (int i = 1; i <= 16; i++) begin
            send8(i[7:0], ok);
            if (!ok) break;
            got++;
        end
        @(negedge clk_a);
        a_valid8 = 1'b0;
        check("b2b accepts", got, 32'd16);
        wait_a_ready8(ok);
        repeat (30) @(negedge clk_b);
        check("b2b count", rx8.size(), base + 16);
        for (int i = 0; i < 16 && base + i < rx8.size(); i++) begin
            check($sformatf("b2b word %0d", i), {24'b0, rx8[base+i]}, i + 1);
        end

        // Sink stall
        @(negedge clk_b);
        b_ready8 = 1'b0;
        base = rx8.size();
        send8(8'h3C, ok);
        @(negedge clk_a);
        a_valid8 = 1'b0;
        wait_b_valid8(ok);
        check("stall b_valid rise", {31'b0, ok}, 32'd1);
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk_b);
            if (!b_valid8 || b_data8 !== 8'h3C || a_ready8) stable = 1'b0;
        end
        check("stall stable", {31'b0, stable}, 32'd1);
        @(negedge clk_b);
        b_ready8 = 1'b1;
        wait_a_ready8(ok);
        check("stall a_ready back", {31'b0, ok}, 32'd1);
        repeat (20) @(negedge clk_b);
        check("stall count", rx8.size(), base + 1);
        if (rx8.size() > base) check("stall data", {24'b0, rx8[base]}, 32'h0000_003C);

        // Reset mid-transfer while the word sits in VALID
        @(negedge clk_b);
        b_ready8 = 1'b0;
        base = rx8.size();
        send8(8'h5A, ok);
        @(negedge clk_a);
        a_valid8 = 1'b0;
        wait_b_valid8(ok);
        check("midrst b_valid rise", {31'b0, ok}, 32'd1);
        @(negedge clk_a);
        #2 async_rst = 1'b0;
        #1;
        check("midrst b_valid", {31'b0, b_valid8}, 32'd0);
        check("midrst a_ready", {31'b0, a_ready8}, 32'd0);
        check("midrst a_rst", {31'b0, a_rst8}, 32'd0);
        check("midrst b_rst", {31'b0, b_rst8}, 32'd0);
        check("midrst b_data", {24'b0, b_data8}, 32'd0);
        #20;
        b_ready8 = 1'b1;
        release_and_check("midrst");
        repeat (40) @(negedge clk_b);
        check("midrst no delivery", rx8.size(), base);
        check("midrst b_valid idle", {31'b0, b_valid8}, 32'd0);
        check("midrst a_ready idle", {31'b0, a_ready8}, 32'd1);

        // Staggered release: clk_b held still while A leaves reset and sends
        run_b = 1'b0;
        #40;
        async_rst = 1'b0;
        #7;
        @(negedge clk_a);
        async_rst = 1'b1;
        repeat (2) @(posedge clk_a);
        #1 check("stag a_rst", {31'b0, a_rst8}, 32'd1);
        check("stag b_rst held", {31'b0, b_rst8}, 32'd0);
        base = rx8.size();
        send8(8'h77, ok);
        check("stag accept", {31'b0, ok}, 32'd1);
        @(negedge clk_a);
        a_valid8 = 1'b0;
        repeat (20) @(negedge clk_a);
        check("stag b_valid idle", {31'b0, b_valid8}, 32'd0);
        check("stag a_ready busy", {31'b0, a_ready8}, 32'd0);
        run_b = 1'b1;
        wait_a_ready8(ok);
        check("stag a_ready back", {31'b0, ok}, 32'd1);
        repeat (20) @(negedge clk_b);
        check("stag count", rx8.size(), base + 1);
        if (rx8.size() > base) check("stag data", {24'b0, rx8[base]}, 32'h0000_0077);

        // Ratio sweep on the 32-bit, 3-stage instance
        half_a = 2.5;
        half_b = 20.0;
        got = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [31:0] w;
                    bit acc;
                    if (i == 70) begin
                        half_a = 20.0;
                        half_b = 2.5;
                    end
                    if (i == 140) begin
                        half_a = 5.0;
                        half_b = 5.0;
                        skew_b = 1.3;
                    end
                    w = $urandom;
                    acc = 1'b0;
                    @(negedge clk_a);
                    a_valid32 = 1'b1;
                    a_data32  = w;
                    for (int k = 0; k < 3000 && !acc; k++) begin
                        if (a_ready32) begin
                            @(posedge clk_a);
                            acc = 1'b1;
                        end else begin
                            @(negedge clk_a);
                        end
                    end
                    if (!acc) begin
                        check("sweep send timeout", 32'd0, 32'd1);
                        break;
                    end
                    exp32.push_back(w);
                    @(negedge clk_a);
                    a_valid32 = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk_a);
                end
            end
            begin
                for (int k = 0; k < 100000 && got < 200; k++) begin
                    @(negedge clk_b);
                    b_ready32 = ($urandom_range(0, 3) != 0);
                    if (b_valid32 && b_ready32) begin
                        rx32.push_back(b_data32);
                        got++;
                    end
                end
            end
        join
        @(negedge clk_b);
        b_ready32 = 1'b1;
        repeat (60) @(negedge clk_b);
        check("sweep rx count", rx32.size(), 32'd200);
        check("sweep accept total", n_acc32, 32'd200);
        check("sweep b_valid idle", {31'b0, b_valid32}, 32'd0);
        for (int i = 0; i < rx32.size() && i < exp32.size(); i++) begin
            check($sformatf("sweep word %0d", i), rx32[i], exp32[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
